// File: rtl/mipi_tx_lane_distributor.sv
// Splits packet words across D-PHY data lanes and frames each lane with
// HS request, prepare, sync byte, data and a per-lane trail sequence.
module mipi_tx_lane_distributor #(
  parameter int               LANES          = 4,
  parameter logic [LANES-1:0] LANE_MASK      = {LANES{1'b1}},
  parameter int               PREPARE_CYCLES = 4,
  parameter int               TRAIL_CYCLES   = 2,
  parameter int               EXIT_CYCLES    = 3,
  parameter logic [7:0]       SYNC_BYTE      = 8'hB8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LANES*8-1:0]   din,
  input  logic                 din_valid,
  input  logic                 din_last,
  input  logic [2:0]           din_bytes,
  output logic                 din_ready,
  output logic [LANES*8-1:0]   dout,
  output logic [LANES-1:0]     validout,
  output logic [LANES-1:0]     hs_req,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_SYNC, S_DATA, S_TRAIL, S_EXIT
  } state_t;

  localparam logic [2:0] LANES_B   = 3'(LANES);
  localparam logic [2:0] TRAIL_N   = 3'(TRAIL_CYCLES);
  localparam logic [3:0] PREP_LOAD = 4'(PREPARE_CYCLES - 1);
  localparam logic [3:0] EXIT_LOAD = 4'(EXIT_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [LANES*8-1:0]        dout_q, dout_d;
  logic [LANES-1:0]          validout_q, validout_d;
  logic [LANES-1:0]          hs_req_q, hs_req_d;
  logic                      error_q, error_d;
  logic [LANES*8-1:0]        last_word_q, last_word_d;
  logic [LANES-1:0][2:0]     trail_left_q, trail_left_d;

  logic                      bytes_bad;
  logic [2:0]                nbytes;
  logic [LANES-1:0]          lane_has_data;
  logic [LANES-1:0][7:0]     lane_trail;
  logic [LANES*8-1:0]        lane_byte_mask;

  assign bytes_bad = (din_bytes == 3'd0) || (din_bytes > LANES_B);
  assign nbytes    = bytes_bad ? LANES_B : din_bytes;

  // Trail level is the inverse of the final bit driven on the lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_has_data[gi]            = (3'(gi) < nbytes);
    assign lane_trail[gi]               = last_word_q[gi*8+7] ? 8'h00 : 8'hFF;
    assign lane_byte_mask[gi*8 +: 8]    = {8{LANE_MASK[gi]}};
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = '0;
    validout_d   = '0;
    hs_req_d     = hs_req_q;
    error_d      = error_q;
    last_word_d  = last_word_q;
    trail_left_d = trail_left_q;
    din_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          state_d  = S_PREP;
          hs_req_d = LANE_MASK;
          cnt_d    = PREP_LOAD;
        end
      end
      S_PREP: begin
        if (cnt_q == 4'd0) state_d = S_SYNC;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SYNC: begin
        dout_d      = {LANES{SYNC_BYTE}};
        validout_d  = LANE_MASK;
        // A lane that never carries data trails off the sync byte.
        last_word_d = {LANES{SYNC_BYTE}};
        state_d     = S_DATA;
      end
      S_DATA: begin
        din_ready  = 1'b1;
        validout_d = LANE_MASK;
        if (!din_valid) begin
          error_d = 1'b1;
          state_d = S_TRAIL;
          for (int i = 0; i < LANES; i++) begin
            dout_d[i*8 +: 8] = lane_trail[i];
            trail_left_d[i]  = TRAIL_N - 3'd1;
          end
        end else if (din_last) begin
          error_d = error_q | bytes_bad;
          state_d = S_TRAIL;
          for (int i = 0; i < LANES; i++) begin
            if (lane_has_data[i]) begin
              dout_d[i*8 +: 8]      = din[i*8 +: 8];
              last_word_d[i*8 +: 8] = din[i*8 +: 8];
              trail_left_d[i]       = TRAIL_N;
            end else begin
              dout_d[i*8 +: 8] = lane_trail[i];
              trail_left_d[i]  = TRAIL_N - 3'd1;
            end
          end
        end else begin
          dout_d      = din;
          last_word_d = din;
        end
      end
      S_TRAIL: begin
        for (int i = 0; i < LANES; i++) begin
          if (trail_left_q[i] != 3'd0) begin
            dout_d[i*8 +: 8] = lane_trail[i];
            validout_d[i]    = 1'b1;
            trail_left_d[i]  = trail_left_q[i] - 3'd1;
          end else begin
            hs_req_d[i] = 1'b0;
          end
        end
        if (hs_req_d == '0) begin
          state_d = S_EXIT;
          cnt_d   = EXIT_LOAD;
        end
      end
      S_EXIT: begin
        hs_req_d = '0;
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    validout_d = validout_d & LANE_MASK;
    dout_d     = dout_d & lane_byte_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dout_q       <= '0;
      validout_q   <= '0;
      hs_req_q     <= '0;
      error_q      <= 1'b0;
      last_word_q  <= '0;
      trail_left_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      validout_q   <= validout_d;
      hs_req_q     <= hs_req_d;
      error_q      <= error_d;
      last_word_q  <= last_word_d;
      trail_left_q <= trail_left_d;
    end
  end

  assign dout     = dout_q;
  assign validout = validout_q;
  assign hs_req   = hs_req_q;
  assign busy     = (state_q != S_IDLE);
  assign error    = error_q;

endmodule
